// File: rtl/muldiv_pkg.sv
// Shared types and funct decoding for the iterative multiply/divide unit.
// Optional feature macro used by the unit: MULDIV_REM_EN (exposes the remainder port).
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    // funct encoding: bit 0 selects divide, bit 1 selects signed operands
    localparam logic [1:0] FUNCT_MUL = 2'b00;
    localparam logic [1:0] FUNCT_DIV = 2'b01;
    localparam logic [1:0] FUNCT_SGN = 2'b10;

    function automatic logic f_is_div(input logic [1:0] f);
        return (f & ~FUNCT_SGN) == FUNCT_DIV;
    endfunction

    function automatic logic f_is_mul(input logic [1:0] f);
        return (f & ~FUNCT_SGN) == FUNCT_MUL;
    endfunction

    function automatic logic f_is_sgn(input logic [1:0] f);
        return (f & FUNCT_SGN) != 2'b00;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
// hi/lo form a 2W accumulator (mul) or remainder/quotient pair (div).
module muldiv_step #(
    parameter int W = 32
) (
    input  logic         is_div_i,
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    logic [W:0]   sum;
    logic [W:0]   trial;
    logic [W-1:0] diff;
    logic         ge;

    always_comb begin
        sum   = {1'b0, hi_i} + {1'b0, m_i};
        trial = {hi_i, lo_i[W-1]};
        ge    = trial >= {1'b0, m_i};
        // remainder stays below the divisor, so the difference always fits in W bits
        diff  = {hi_i[W-2:0], lo_i[W-1]} - m_i;
        hi_o  = hi_i;
        lo_o  = lo_i;
        if (is_div_i) begin
            if (ge) begin
                hi_o = diff;
                lo_o = {lo_i[W-2:0], 1'b1};
            end else begin
                hi_o = trial[W-1:0];
                lo_o = {lo_i[W-2:0], 1'b0};
            end
        end else if (lo_i[0]) begin
            {hi_o, lo_o} = {sum, lo_i[W-1:1]};
        end else begin
            {hi_o, lo_o} = {1'b0, hi_i, lo_i[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply (low half) / divide, one bit per cycle, valid/ready on both sides.
// Define MULDIV_REM_EN to expose the remainder port.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   funct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] calres,
    output logic         ovf,
    output logic         sn
`ifdef MULDIV_REM_EN
   ,output logic [W-1:0] rem
`endif
);

    localparam int CNT_W = $clog2(W+1);
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    state_e           state_q;
    logic [W-1:0]     a_q, b_q, m_q, hi_q, lo_q;
    logic [1:0]       funct_q;
    logic             neg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q, out_valid_q, ovf_q, sn_q;
    logic [W-1:0]     calres_q;

    logic             is_div, sgn, div0, minneg;
    logic [W-1:0]     a_abs, b_abs, hi_d, lo_d, quot_s;
    logic [2*W-1:0]   prod_s;
    logic [W-1:0]     calres_d;
    logic             ovf_d, sn_d;

`ifdef MULDIV_REM_EN
    logic             rneg_q;
    logic [W-1:0]     rem_q, rem_d;
`endif

    always_comb begin
        is_div = f_is_div(funct_q);
        sgn    = f_is_sgn(funct_q);
        a_abs  = (sgn && a_q[W-1]) ? -a_q : a_q;
        b_abs  = (sgn && b_q[W-1]) ? -b_q : b_q;
        div0   = (b_q == '0);
        minneg = sgn && (a_q == MIN_V) && (b_q == '1);
    end

    muldiv_step #(.W(W)) u_step (
        .is_div_i (is_div),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .m_i      (m_q),
        .hi_o     (hi_d),
        .lo_o     (lo_d)
    );

    // Sign fix-up and flags, consumed in FIX
    always_comb begin
        prod_s   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quot_s   = neg_q ? -lo_q : lo_q;
        calres_d = quot_s;
        ovf_d    = 1'b0;
`ifdef MULDIV_REM_EN
        rem_d    = rneg_q ? -hi_q : hi_q;
`endif
        if (f_is_mul(funct_q)) begin
            calres_d = prod_s[W-1:0];
            ovf_d    = sgn ? (prod_s[2*W-1:W] != {W{prod_s[W-1]}})
                           : (prod_s[2*W-1:W] != '0);
`ifdef MULDIV_REM_EN
            rem_d    = '0;
`endif
        end else if (div0) begin
            calres_d = '1;
            ovf_d    = 1'b1;
`ifdef MULDIV_REM_EN
            rem_d    = a_q;
`endif
        end else if (minneg) begin
            calres_d = MIN_V;
            ovf_d    = 1'b1;
`ifdef MULDIV_REM_EN
            rem_d    = '0;
`endif
        end
        sn_d = sgn & calres_d[W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            calres_q    <= '0;
            ovf_q       <= 1'b0;
            sn_q        <= 1'b0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            funct_q     <= '0;
            neg_q       <= 1'b0;
`ifdef MULDIV_REM_EN
            rneg_q      <= 1'b0;
            rem_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        funct_q    <= funct;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    hi_q    <= '0;
                    lo_q    <= is_div ? a_abs : b_abs;
                    m_q     <= is_div ? b_abs : a_abs;
                    neg_q   <= sgn & (a_q[W-1] ^ b_q[W-1]);
`ifdef MULDIV_REM_EN
                    rneg_q  <= sgn & a_q[W-1];
`endif
                    cnt_q   <= CNT_W'(W-1);
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    if (cnt_q == '0) state_q <= ST_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                ST_FIX: begin
                    calres_q    <= calres_d;
                    ovf_q       <= ovf_d;
                    sn_q        <= sn_d;
`ifdef MULDIV_REM_EN
                    rem_q       <= rem_d;
`endif
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign calres    = calres_q;
    assign ovf       = ovf_q;
    assign sn        = sn_q;
`ifdef MULDIV_REM_EN
    assign rem       = rem_q;
`endif

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: vector table, random ops against a reference model,
// backpressure and mid-operation reset sequences, with a scoreboard queue of expected results.
module tb_muldiv_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   funct = 2'b00;
    logic         in_ready, out_valid, ovf, sn;
    logic [W-1:0] calres;
`ifdef MULDIV_REM_EN
    logic [W-1:0] rem;
`endif

    always #5 clk = ~clk;

    muldiv_iter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .funct     (funct),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .calres    (calres),
        .ovf       (ovf),
        .sn        (sn)
`ifdef MULDIV_REM_EN
       ,.rem       (rem)
`endif
    );

    typedef struct {
        logic [W-1:0] a, b;
        logic [1:0]   f;
        logic [W-1:0] c;
        logic         o, s;
        logic [W-1:0] r;
        logic         cr;
    } vec_t;

    typedef struct {
        logic [W-1:0] c;
        logic         o, s;
        logic [W-1:0] r;
        logic         cr;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vt[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ia, ib, input logic [1:0] f);
        exp_t e;
        logic signed [2*W-1:0] ps;
        logic [2*W-1:0]        pu;
        logic signed [W-1:0]   sa, sb;
        sa = ia; sb = ib;
        e.r = '0; e.o = 1'b0; e.cr = f[0];
        if (!f[0]) begin
            if (f[1]) begin
                ps  = $signed({{W{ia[W-1]}}, ia}) * $signed({{W{ib[W-1]}}, ib});
                e.c = ps[W-1:0];
                e.o = ps[2*W-1:W] != {W{ps[W-1]}};
            end else begin
                pu  = {{W{1'b0}}, ia} * {{W{1'b0}}, ib};
                e.c = pu[W-1:0];
                e.o = pu[2*W-1:W] != '0;
            end
        end else if (ib == '0) begin
            e.c = '1; e.r = ia; e.o = 1'b1;
        end else if (f[1] && ia == {1'b1, {(W-1){1'b0}}} && ib == '1) begin
            e.c = ia; e.r = '0; e.o = 1'b1;
        end else if (f[1]) begin
            e.c = sa / sb; e.r = sa % sb;
        end else begin
            e.c = ia / ib; e.r = ia % ib;
        end
        e.s = f[1] & e.c[W-1];
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] ia, ib, input logic [1:0] f, input exp_t e, input bit push);
        int t = 0;
        while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL issue_wait: in_ready=0 after 100 cycles, expected 1");
        end
        a = ia; b = ib; funct = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; funct = 2'($urandom_range(0, 3));
        if (push) sbq.push_back(e);
    endtask

    task automatic compare(input string nm, input exp_t e);
        check({nm, ".calres"}, calres, e.c);
        check({nm, ".ovf"}, ovf, e.o);
        check({nm, ".sn"}, sn, e.s);
`ifdef MULDIV_REM_EN
        if (e.cr) check({nm, ".rem"}, rem, e.r);
`endif
    endtask

    // Call right after issue(): waits for out_valid, checks latency, pops and compares, handshakes.
    task automatic collect(input string nm);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check({nm, ".latency"}, lat, W + 2);
        if (sbq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s.scoreboard: result with empty queue, expected a pending entry", nm);
        end else begin
            e = sbq.pop_front();
            compare(nm, e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] ra, rb;
        logic [1:0]   rf;

        vt[0]  = '{32'h0001_0000, 32'h0001_0000, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 32'h0, 1'b0};
        vt[1]  = '{32'hFFFF_FFFD, 32'h0000_0007, 2'b10, 32'hFFFF_FFEB, 1'b0, 1'b1, 32'h0, 1'b0};
        vt[2]  = '{32'hFFFF_FFF9, 32'h0000_0002, 2'b11, 32'hFFFF_FFFD, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vt[3]  = '{32'h0000_0005, 32'h0000_0000, 2'b01, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0005, 1'b1};
        vt[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1};
        vt[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, 1'b1, 1'b0, 32'h0, 1'b0};
        vt[6]  = '{32'd100,       32'd7,         2'b01, 32'd14,        1'b0, 1'b0, 32'd2, 1'b1};
        vt[7]  = '{32'd7,         32'hFFFF_FFFE, 2'b11, 32'hFFFF_FFFD, 1'b0, 1'b1, 32'd1, 1'b1};
        vt[8]  = '{32'h4000_0000, 32'd2,         2'b10, 32'h8000_0000, 1'b1, 1'b1, 32'h0, 1'b0};
        vt[9]  = '{32'd5,         32'd0,         2'b11, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd5, 1'b1};
        vt[10] = '{32'd1234,      32'd5678,      2'b00, 32'h006A_E9BC, 1'b0, 1'b0, 32'h0, 1'b0};
        vt[11] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 2'b11, 32'd14,        1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", in_ready, 1'b1);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.calres", calres, '0);
        check("reset.ovf", ovf, 1'b0);
        check("reset.sn", sn, 1'b0);
`ifdef MULDIV_REM_EN
        check("reset.rem", rem, '0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            e = '{vt[i].c, vt[i].o, vt[i].s, vt[i].r, vt[i].cr};
            issue(vt[i].a, vt[i].b, vt[i].f, e, 1'b1);
            collect($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? W'($urandom_range(0, 15)) : $urandom;
            rf = 2'($urandom_range(0, 3));
            issue(ra, rb, rf, model(ra, rb, rf), 1'b1);
            collect($sformatf("rnd%0d", i));
        end

        // backpressure: result held in DONE while in_valid is ignored
        begin
            int lat = 0;
            e = model(32'd3, 32'd4, 2'b00);
            issue(32'd3, 32'd4, 2'b00, e, 1'b1);
            while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
            check("bp.latency", lat, W + 2);
            e = sbq.pop_front();
            for (int k = 0; k < 5; k++) begin
                in_valid = 1'b1; a = 32'd99; b = 32'd9; funct = 2'b01;
                @(posedge clk); #1;
                check("bp.out_valid", out_valid, 1'b1);
                check("bp.in_ready", in_ready, 1'b0);
                check("bp.calres", calres, e.c);
            end
            in_valid = 1'b0;
            compare("bp", e);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("bp.post_in_ready", in_ready, 1'b1);
            check("bp.post_out_valid", out_valid, 1'b0);
        end

        // reset during CALC cycle 10 discards the op
        e = model(32'd1000, 32'd3, 2'b01);
        issue(32'd1000, 32'd3, 2'b01, e, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mrst.in_ready", in_ready, 1'b1);
        check("mrst.out_valid", out_valid, 1'b0);
        check("mrst.calres", calres, '0);
        check("mrst.ovf", ovf, 1'b0);
        check("mrst.sn", sn, 1'b0);
        e = model(32'hFFFF_FF00, 32'd16, 2'b11);
        issue(32'hFFFF_FF00, 32'd16, 2'b11, e, 1'b1);
        collect("mrst.fresh");

        check("sb.empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
